// File: rtl/native_bus_initiator.sv
// Native-bus initiator: accepts one command at a time, issues a single EN strobe,
// masks the responder's stale READY for a guard window, then waits for READY or times out.
module native_bus_initiator #(
    parameter int NATIVE_ADDR_WIDTH = 2,
    parameter int NATIVE_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES    = 255,
    parameter int READY_GUARD       = 2
) (
    input  logic                         NATIVE_CLK,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_wr,
    input  logic [NATIVE_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [NATIVE_DATA_WIDTH-1:0] cmd_wdata,
    output logic                         NATIVE_EN,
    output logic                         NATIVE_WR,
    output logic [NATIVE_ADDR_WIDTH-1:0] NATIVE_ADDR,
    output logic [NATIVE_DATA_WIDTH-1:0] NATIVE_DATA_OUT,
    input  logic [NATIVE_DATA_WIDTH-1:0] NATIVE_DATA_IN,
    input  logic                         NATIVE_READY,
    output logic                         rsp_valid,
    output logic [NATIVE_DATA_WIDTH-1:0] rsp_rdata,
    output logic                         rsp_err,
    output logic                         busy
);

    typedef enum logic [2:0] {IDLE, ISSUE, GUARD, WAIT, RESP} state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  GUARD_LAST   = 3'(READY_GUARD - 1);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  guard_cnt;
    logic [15:0] wait_cnt;
    logic        accept;
    logic        ready_hit;
    logic        timeout_hit;

    assign accept      = cmd_valid && (state == IDLE);
    // READY beats the timeout when both land in the same WAIT cycle
    assign ready_hit   = (state == WAIT) && NATIVE_READY;
    assign timeout_hit = (state == WAIT) && !NATIVE_READY && (wait_cnt == TIMEOUT_LAST);

    always_ff @(posedge NATIVE_CLK) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        NATIVE_EN = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (accept) state_nxt = ISSUE;
            end
            ISSUE: begin
                NATIVE_EN = 1'b1;
                state_nxt = GUARD;
            end
            GUARD: begin
                if (guard_cnt == GUARD_LAST) state_nxt = WAIT;
            end
            WAIT: begin
                if (ready_hit || timeout_hit) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Both counters restart from zero whenever their state is entered
    always_ff @(posedge NATIVE_CLK) begin
        if (rst) begin
            guard_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            guard_cnt <= (state == GUARD) ? guard_cnt + 3'd1 : 3'd0;
            if (state != WAIT) begin
                wait_cnt <= '0;
            end else if (wait_cnt != 16'hFFFF) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge NATIVE_CLK) begin
        if (rst) begin
            NATIVE_WR       <= 1'b0;
            NATIVE_ADDR     <= '0;
            NATIVE_DATA_OUT <= '0;
        end else if (accept) begin
            NATIVE_WR       <= cmd_wr;
            NATIVE_ADDR     <= cmd_addr;
            NATIVE_DATA_OUT <= cmd_wdata;
        end
    end

    always_ff @(posedge NATIVE_CLK) begin
        if (rst) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (ready_hit) begin
            rsp_rdata <= NATIVE_WR ? '0 : NATIVE_DATA_IN;
            rsp_err   <= 1'b0;
        end else if (timeout_hit) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_native_bus_initiator.sv
// Directed bench for native_bus_initiator: write, read, stale READY, timeout,
// READY-on-timeout, mid-transaction reset and busy command rejection.
module tb_native_bus_initiator;

    localparam int AW = 2;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam int G  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          NATIVE_EN;
    logic          NATIVE_WR;
    logic [AW-1:0] NATIVE_ADDR;
    logic [DW-1:0] NATIVE_DATA_OUT;
    logic [DW-1:0] NATIVE_DATA_IN;
    logic          NATIVE_READY;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    int en_cnt   = 0;
    int rsp_cnt  = 0;

    native_bus_initiator #(
        .NATIVE_ADDR_WIDTH(AW),
        .NATIVE_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO),
        .READY_GUARD(G)
    ) dut (
        .NATIVE_CLK(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .NATIVE_EN(NATIVE_EN),
        .NATIVE_WR(NATIVE_WR),
        .NATIVE_ADDR(NATIVE_ADDR),
        .NATIVE_DATA_OUT(NATIVE_DATA_OUT),
        .NATIVE_DATA_IN(NATIVE_DATA_IN),
        .NATIVE_READY(NATIVE_READY),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (NATIVE_EN) en_cnt++;
        if (rsp_valid) rsp_cnt++;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One command from accept to the cycle after its response; READY is raised
    // ready_at cycles after the EN cycle (0 = never), optionally preceded by a stale READY.
    task automatic txn(input string tag, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                       input int ready_at, input bit stale, input bit poke,
                       input int exp_lat, input logic exp_err, input logic [DW-1:0] exp_rdata);
        int en0;
        int lat;
        bit seen;
        en0  = en_cnt;
        seen = 0;
        lat  = 0;
        check_val({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        cmd_valid      = 1'b1;
        cmd_wr         = wr;
        cmd_addr       = addr;
        cmd_wdata      = wdata;
        NATIVE_DATA_IN = rdata;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            cmd_valid = poke && (k <= 4);
            if (poke) begin
                cmd_wr    = ~wr;
                cmd_addr  = ~addr;
                cmd_wdata = ~wdata;
            end
            if (k == 1) begin
                check_val({tag, "_en"},   64'(NATIVE_EN), 64'd1);
                check_val({tag, "_wr"},   64'(NATIVE_WR), 64'(wr));
                check_val({tag, "_addr"}, 64'(NATIVE_ADDR), 64'(addr));
                check_val({tag, "_dout"}, 64'(NATIVE_DATA_OUT), 64'(wdata));
            end
            if (rsp_valid) begin
                seen         = 1;
                lat          = k + 1;
                NATIVE_READY = 1'b0;
            end else begin
                NATIVE_READY = (stale && k <= 1 + G) || (ready_at > 0 && k >= 1 + ready_at);
            end
        end
        check_val({tag, "_rsp_seen"}, 64'(seen), 64'd1);
        check_val({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check_val({tag, "_err"},   64'(rsp_err), 64'(exp_err));
        check_val({tag, "_rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
        check_val({tag, "_en_pulses"}, 64'(en_cnt - en0), 64'd1);
        cmd_valid = 1'b0;
        @(negedge clk);
        check_val({tag, "_rsp_single"}, 64'(rsp_valid), 64'd0);
        check_val({tag, "_rdata_hold"}, 64'(rsp_rdata), 64'(exp_rdata));
        check_val({tag, "_err_hold"},   64'(rsp_err), 64'(exp_err));
        check_val({tag, "_addr_hold"},  64'(NATIVE_ADDR), 64'(addr));
        check_val({tag, "_ready_after"}, 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        int r0;
        rst            = 1'b1;
        cmd_valid      = 1'b0;
        cmd_wr         = 1'b0;
        cmd_addr       = '0;
        cmd_wdata      = '0;
        NATIVE_DATA_IN = '0;
        NATIVE_READY   = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_en",    64'(NATIVE_EN), 64'd0);
        check_val("rst_wr",    64'(NATIVE_WR), 64'd0);
        check_val("rst_rsp",   64'(rsp_valid), 64'd0);
        check_val("rst_err",   64'(rsp_err), 64'd0);
        check_val("rst_busy",  64'(busy), 64'd0);
        check_val("rst_addr",  64'(NATIVE_ADDR), 64'd0);
        check_val("rst_dout",  64'(NATIVE_DATA_OUT), 64'd0);
        check_val("rst_rdata", 64'(rsp_rdata), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // latency counts the accept cycle and the response cycle: 3 + G + N
        txn("write", 1'b1, 2'd1, 32'h0000_0123, 32'h5555_AAAA, 4, 1'b0, 1'b0,
            3 + G + 2, 1'b0, 32'h0);
        txn("read", 1'b0, 2'd2, 32'h0, 32'hDEAD_BEEF, 3, 1'b0, 1'b0,
            3 + G + 1, 1'b0, 32'hDEAD_BEEF);
        txn("stale", 1'b0, 2'd3, 32'h0, 32'h0BAD_F00D, 5, 1'b1, 1'b0,
            3 + G + 3, 1'b0, 32'h0BAD_F00D);
        txn("timeout", 1'b0, 2'd1, 32'h0, 32'h1234_5678, 0, 1'b0, 1'b0,
            3 + G + TO, 1'b1, 32'h0);
        txn("simul", 1'b0, 2'd0, 32'h0, 32'hCAFE_0042, 2 + TO, 1'b0, 1'b0,
            3 + G + TO, 1'b0, 32'hCAFE_0042);

        // reset lands in WAIT; a late READY afterwards must be ignored
        r0             = rsp_cnt;
        cmd_valid      = 1'b1;
        cmd_wr         = 1'b0;
        cmd_addr       = 2'd3;
        NATIVE_DATA_IN = 32'hFEED_0001;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_val("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_val("mrst_busy",      64'(busy), 64'd0);
        check_val("mrst_cmd_ready", 64'(cmd_ready), 64'd1);
        check_val("mrst_en",        64'(NATIVE_EN), 64'd0);
        check_val("mrst_addr",      64'(NATIVE_ADDR), 64'd0);
        check_val("mrst_rdata",     64'(rsp_rdata), 64'd0);
        check_val("mrst_err",       64'(rsp_err), 64'd0);
        rst          = 1'b0;
        NATIVE_READY = 1'b1;
        repeat (4) @(negedge clk);
        NATIVE_READY = 1'b0;
        check_val("mrst_no_rsp",  64'(rsp_cnt - r0), 64'd0);
        check_val("mrst_idle",    64'(busy), 64'd0);

        txn("busy_poke", 1'b1, 2'd2, 32'hA5A5_0F0F, 32'h0, 3, 1'b0, 1'b1,
            3 + G + 1, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/native_bus_initiator.md
NATIVE_BUS_INITIATOR -- requirements
Module: native_bus_initiator

Interface
REQ-001 Parameter NATIVE_ADDR_WIDTH, default 2, native address width.
REQ-002 Parameter NATIVE_DATA_WIDTH, default 32, native data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, maximum number of WAIT cycles before an error completion; the legal range is 1..65535.
REQ-004 Parameter READY_GUARD, default 2, number of cycles after the EN pulse during which NATIVE_READY is ignored; the legal range is 1..7.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 NATIVE_CLK  in  1  sole clock; all logic is on the rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 cmd_valid  in  1  command request.
REQ-009 cmd_ready  out  1  initiator can accept a command.
REQ-010 cmd_wr  in  1  1 = write, 0 = read.
REQ-011 cmd_addr  in  NATIVE_ADDR_WIDTH  target address.
REQ-012 cmd_wdata  in  NATIVE_DATA_WIDTH  write data.
REQ-013 NATIVE_EN  out  1  one-cycle transaction strobe.
REQ-014 NATIVE_WR  out  1  write qualifier.
REQ-015 NATIVE_ADDR  out  NATIVE_ADDR_WIDTH  address.
REQ-016 NATIVE_DATA_OUT  out  NATIVE_DATA_WIDTH  write data to the responder.
REQ-017 NATIVE_DATA_IN  in  NATIVE_DATA_WIDTH  read data from the responder.
REQ-018 NATIVE_READY  in  1  responder completion level.
REQ-019 rsp_valid  out  1  one-cycle completion pulse.
REQ-020 rsp_rdata  out  NATIVE_DATA_WIDTH  read data; 0 on writes and on errors.
REQ-021 rsp_err  out  1  timeout flag, valid together with rsp_valid.
REQ-022 busy  out  1  high in every state except IDLE.

Function
REQ-023 FSM states SHALL be IDLE, ISSUE, GUARD, WAIT and RESP.
REQ-024 cmd_ready SHALL equal (state == IDLE) and SHALL NOT depend combinationally on cmd_valid.
REQ-025 IDLE: on cmd_valid & cmd_ready, the block SHALL register cmd_wr, cmd_addr and cmd_wdata, then go to ISSUE on the next cycle.
REQ-026 ISSUE: NATIVE_EN SHALL be 1 for exactly this one cycle, with NATIVE_WR/ADDR/DATA_OUT driven from the registered command; the state then goes to GUARD.
REQ-027 NATIVE_WR, NATIVE_ADDR and NATIVE_DATA_OUT SHALL hold their values from ISSUE until the next command is accepted.
REQ-028 GUARD: NATIVE_READY SHALL be ignored for READY_GUARD cycles, because the responder returns a stale READY; the state then goes to WAIT.
REQ-029 WAIT: a 16-bit timeout counter SHALL clear on entry and increment every cycle.
REQ-030 WAIT: on NATIVE_READY = 1 the block SHALL capture NATIVE_DATA_IN for reads (0 for writes), set rsp_err = 0 and go to RESP.
REQ-031 WAIT: when the counter reaches TIMEOUT_CYCLES-1 with NATIVE_READY still 0, the block SHALL set rsp_rdata = 0 and rsp_err = 1, then go to RESP.
REQ-032 WAIT: if READY and the timeout occur in the same cycle, READY SHALL win and rsp_err SHALL be 0.
REQ-033 RESP: rsp_valid SHALL be 1 for exactly one cycle, then the state returns to IDLE.
REQ-034 rsp_rdata and rsp_err SHALL hold until the next RESP.
REQ-035 Latency from command accept to rsp_valid SHALL be 3 + READY_GUARD + N cycles, where N is the number of WAIT cycles (N ≥ 1).
REQ-036 A back-to-back command SHALL be accepted no earlier than the cycle after RESP.
REQ-037 cmd_valid asserted while busy SHALL be ignored, with no queuing.
REQ-038 The counter SHALL saturate and never wrap.

Reset
REQ-039 When rst is 1 at a clock edge, the state SHALL go to IDLE and the counter SHALL clear.
REQ-040 During reset, NATIVE_EN, NATIVE_WR, rsp_valid, rsp_err and busy SHALL be 0, and cmd_ready SHALL be 1 from the first cycle after reset.
REQ-041 During reset, NATIVE_ADDR, NATIVE_DATA_OUT and rsp_rdata SHALL be 0.
REQ-042 A reset mid-transaction SHALL abort the transaction without producing rsp_valid.
REQ-043 A READY arriving after a reset that occurred mid-transaction SHALL be ignored in IDLE.

Verification
REQ-044 Write test: write addr 1, data 0x0000_0123, responder READY 4 cycles after EN → exactly one EN pulse with WR = 1, ADDR = 1, DATA_OUT = 0x123; then rsp_valid with err = 0 and rdata = 0.
REQ-045 Read test: read addr 2, responder returns 0xDEAD_BEEF with READY → rsp_rdata = 0xDEADBEEF, err = 0, and latency matches REQ-035.
REQ-046 Stale-READY test: READY held at 1 throughout GUARD, then dropped and re-raised → completion occurs only on the re-raise in WAIT.
REQ-047 Timeout test: TIMEOUT_CYCLES = 8, READY never asserts → rsp_valid with err = 1 and rdata = 0 exactly 8 WAIT cycles after GUARD ends.
REQ-048 Simultaneous test: READY asserts on the final timeout cycle → err = 0 and data captured.
REQ-049 Reset and busy test: rst pulsed during WAIT → no rsp_valid, cmd_ready = 1 the next cycle; a cmd_valid presented while busy produces no second EN pulse.
